// File: rtl/i2c_eeprom_slave.sv
// 24C02-style I2C EEPROM responder (256x8, byte/page write, current/random/sequential read); `I2C_SLAVE_WP_EN adds wp.
// Bus events act 3 clk after the pin edge; sda_oe moves only on scl fall; a write commits on its ACK fall.
// Never stretches scl: the master always sets the pace; wp (when built in) NACKs data bytes instead.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter int         MEM_DEPTH = 256,
  parameter int         PAGE_SIZE = 8,
  parameter logic [7:0] INIT_VAL  = 8'hFF,
  localparam int        AW        = $clog2(MEM_DEPTH),
  localparam int        PW        = $clog2(PAGE_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
`ifdef I2C_SLAVE_WP_EN
  input  logic          wp,
`endif
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK
  } state_t;

  // [1:0] synchroniser, [2] history for edge detection
  logic [2:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    tx_q, tx_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_ptr_q, addr_ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [MEM_DEPTH];

  logic          scl_hi, scl_rise, scl_fall, sda_bit, sda_rise, sda_fall;
  logic          start_evt, stop_evt, wp_on;
  logic [AW-1:0] page_next;
  logic [7:0]    rd_byte;

`ifdef I2C_SLAVE_WP_EN
  logic [1:0] wp_sync_q, wp_sync_d;
  assign wp_sync_d = {wp_sync_q[0], wp};
  assign wp_on     = wp_sync_q[1];
`else
  assign wp_on     = 1'b0;
`endif

  assign scl_sync_d = {scl_sync_q[1:0], scl_in};
  assign sda_sync_d = {sda_sync_q[1:0], sda_in};
  assign scl_hi     = scl_sync_q[1];
  assign scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_bit    = sda_sync_q[1];
  assign sda_rise   = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall   = ~sda_sync_q[1] & sda_sync_q[2];
  assign start_evt  = sda_fall & scl_hi;
  assign stop_evt   = sda_rise & scl_hi;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    addr_ptr_d = addr_ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_byte    = mem_q[addr_ptr_q];
    // page writes wrap inside the page; the page number never changes
    page_next           = addr_ptr_q;
    page_next[PW-1:0]   = addr_ptr_q[PW-1:0] + PW'(1);

    if (start_evt) begin
      state_d   = DEV;
      bit_cnt_d = 4'd0;
      shreg_d   = 8'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_evt) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        DEV, WADDR, WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == DEV) begin
              if (shreg_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                state_d  = DEV_ACK;
                rw_d     = shreg_q[0];
                busy_d   = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == WADDR) begin
              addr_ptr_d = shreg_q[AW-1:0];
              sda_oe_d   = 1'b1;
              state_d    = WADDR_ACK;
            end else begin
              state_d = WDATA_ACK;
              if (!wp_on) begin
                sda_oe_d   = 1'b1;
                wr_stb_d   = 1'b1;
                wr_addr_d  = addr_ptr_q;
                wr_data_d  = shreg_q;
                addr_ptr_d = page_next;
              end
            end
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d   = RDATA;
              sda_oe_d  = ~rd_byte[7];
              tx_d      = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = WADDR;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              shreg_d   = 8'd0;
            end
          end
        end
        WADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = WDATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            shreg_d   = 8'd0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              state_d   = RD_ACK;
              bit_cnt_d = 4'd0;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          // bit_cnt marks that the master ACKed during this slot
          if (scl_rise) begin
            if (sda_bit) begin
              state_d = IDLE;
            end else begin
              addr_ptr_d = addr_ptr_q + AW'(1);
              bit_cnt_d  = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = RDATA;
            sda_oe_d  = ~rd_byte[7];
            tx_d      = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
`ifdef I2C_SLAVE_WP_EN
      wp_sync_q  <= 2'b00;
`endif
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'd0;
      tx_q       <= 8'd0;
      rw_q       <= 1'b0;
      addr_ptr_q <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
`ifdef I2C_SLAVE_WP_EN
      wp_sync_q  <= wp_sync_d;
`endif
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      addr_ptr_q <= addr_ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (wr_stb_d) mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged I2C master drives the bus while an
// array/pointer model of the EEPROM predicts read data and the committed-write stream.
module tb_i2c_eeprom_slave;

  localparam int Q    = 20;   // clk per quarter of an scl period
  localparam int PAGE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] wr_addr, wr_data;
`ifdef I2C_SLAVE_WP_EN
  logic       wp = 1'b0;
`endif

  assign sda_line = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl),
    .sda_in  (sda_line),
`ifdef I2C_SLAVE_WP_EN
    .wp      (wp),
`endif
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  int          errors = 0;
  int          checks = 0;
  int          stb_seen = 0;
  int          oe_cnt = 0;
  logic [7:0]  m_mem [256];
  int          m_ptr = 0;
  bit          wp_model = 1'b0;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  rd_log [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // EEPROM model: plain array plus pointer arithmetic
  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
    m_ptr = 0;
  endtask

  task automatic model_write_byte(input logic [7:0] d);
    if (!wp_model) begin
      m_mem[m_ptr] = d;
      exp_wr_q.push_back({8'(m_ptr), d});
      m_ptr = (m_ptr / PAGE) * PAGE + (m_ptr + 1) % PAGE;
    end
  endtask

  // Single compare process for the committed-write stream and sda activity
  always @(negedge clk) begin : cmp
    logic [15:0] e;
    if (!rst) begin
      if (sda_oe) oe_cnt++;
      if (wr_stb) begin
        stb_seen++;
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_stb_unexpected: got addr 0x%0h data 0x%0h, expected no strobe", wr_addr, wr_data);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_event", {16'd0, wr_addr, wr_data}, {16'd0, e});
        end
      end
    end
  end

  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; waitq();
    scl = 1'b1;   waitq();
    sda_m = 1'b0; waitq();
    scl = 1'b0;   waitq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; waitq();
    scl = 1'b1;   waitq();
    sda_m = 1'b1; waitq();
    waitq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  waitq();
    scl = 1'b1; waitq(); waitq();
    scl = 1'b0; waitq();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; waitq();
    scl = 1'b1;   waitq();
    b = sda_line; waitq();
    scl = 1'b0;   waitq();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input bit ack_it, output logic oe_at_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    sda_m = ack_it ? 1'b0 : 1'b1; waitq();
    scl = 1'b1;                   waitq();
    oe_at_ack = sda_oe;           waitq();
    scl = 1'b0;                   waitq();
  endtask

  task automatic read_seq(input logic [7:0] a, input int n, input bit set_addr);
    logic       ack, rel;
    logic [7:0] d, exp;
    if (set_addr) begin
      bus_start();
      send_byte(8'hA0, ack); check("rd_dev_w_ack", {31'd0, ack}, 32'd1);
      send_byte(a, ack);     check("rd_waddr_ack", {31'd0, ack}, 32'd1);
      m_ptr = int'(a);
    end
    bus_start();
    send_byte(8'hA1, ack); check("rd_dev_r_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      exp = m_mem[m_ptr];
      recv_byte(d, i < n - 1, rel);
      check("rd_data", {24'd0, d}, {24'd0, exp});
      check("rd_sda_released_at_ack", {31'd0, rel}, 32'd0);
      rd_log[i] = d;
      if (i < n - 1) m_ptr = (m_ptr + 1) % 256;
    end
    bus_stop();
  endtask

  initial begin
    logic ack;
    int   oe0;
    model_reset();

    // reset state
    repeat (5) @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    waitq();

    // byte write 0xF1 -> 0x03
    bus_start();
    send_byte(8'hA0, ack); check("bw_dev_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h03, ack); check("bw_waddr_ack", {31'd0, ack}, 32'd1);
    m_ptr = 3;
    model_write_byte(8'hF1);
    send_byte(8'hF1, ack); check("bw_data_ack", {31'd0, ack}, 32'd1);
    check("bw_busy_in_frame", {31'd0, busy}, 32'd1);
    bus_stop();
    check("bw_busy_after_stop", {31'd0, busy}, 32'd0);
    check("bw_stb_count", stb_seen, 32'd1);

    // random read of 0x03
    read_seq(8'h03, 1, 1'b1);
    check("rr_literal", {24'd0, rd_log[0]}, 32'h0000_00F1);

    // wrong device address: silent for the whole frame
    oe0 = oe_cnt;
    bus_start();
    send_byte(8'hB0, ack); check("wa_no_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h03, ack);
    send_byte(8'h77, ack);
    check("wa_oe_quiet", oe_cnt - oe0, 32'd0);
    check("wa_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    read_seq(8'h03, 1, 1'b1);
    check("wa_mem_unchanged", {24'd0, rd_log[0]}, 32'h0000_00F1);

    // page write wrapping 0x06 -> 0x07 -> 0x00
    bus_start();
    send_byte(8'hA0, ack); check("pw_dev_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h06, ack); check("pw_waddr_ack", {31'd0, ack}, 32'd1);
    m_ptr = 6;
    model_write_byte(8'h11); send_byte(8'h11, ack); check("pw_ack0", {31'd0, ack}, 32'd1);
    model_write_byte(8'h22); send_byte(8'h22, ack); check("pw_ack1", {31'd0, ack}, 32'd1);
    model_write_byte(8'h33); send_byte(8'h33, ack); check("pw_ack2", {31'd0, ack}, 32'd1);
    bus_stop();
    check("pw_stb_count", stb_seen, 32'd4);
    read_seq(8'h06, 2, 1'b1);
    check("pw_lit_06", {24'd0, rd_log[0]}, 32'h11);
    check("pw_lit_07", {24'd0, rd_log[1]}, 32'h22);
    read_seq(8'h00, 1, 1'b1);
    check("pw_lit_00", {24'd0, rd_log[0]}, 32'h33);
    read_seq(8'hFF, 2, 1'b1);
    check("seq_lit_ff", {24'd0, rd_log[0]}, 32'hFF);
    check("seq_lit_wrap", {24'd0, rd_log[1]}, 32'h33);

    // current-address read continues from 0x00
    read_seq(8'h00, 1, 1'b0);
    check("cur_lit", {24'd0, rd_log[0]}, 32'h33);

    // partial data byte then STOP: nothing committed, pointer stays at 0x03
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    m_ptr = 3;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    check("abort_stb_count", stb_seen, 32'd4);
    read_seq(8'h00, 1, 1'b0);
    check("abort_ptr_lit", {24'd0, rd_log[0]}, 32'hF1);

    // reset while the slave drives bit 7 (0) of mem[0x00]
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    bus_start();
    send_byte(8'hA1, ack);
    check("mr_oe_driving", {31'd0, sda_oe}, 32'd1);
    @(negedge clk);
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    @(posedge clk); #1;
    check("mr_oe_released", {31'd0, sda_oe}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    model_reset();
    waitq();
    check("mr_busy", {31'd0, busy}, 32'd0);
    read_seq(8'h00, 1, 1'b0);
    check("mr_cur_lit", {24'd0, rd_log[0]}, 32'hFF);
    read_seq(8'h03, 1, 1'b1);
    check("mr_mem_lit", {24'd0, rd_log[0]}, 32'hFF);

`ifdef I2C_SLAVE_WP_EN
    wp = 1'b1; wp_model = 1'b1;
    waitq();
    bus_start();
    send_byte(8'hA0, ack); check("wp_dev_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h10, ack); check("wp_waddr_ack", {31'd0, ack}, 32'd1);
    m_ptr = 16;
    model_write_byte(8'h55);
    send_byte(8'h55, ack); check("wp_data_nack", {31'd0, ack}, 32'd0);
    bus_stop();
    read_seq(8'h10, 1, 1'b1);
    check("wp_mem_lit", {24'd0, rd_log[0]}, 32'hFF);
    wp = 1'b0; wp_model = 1'b0;
`endif

    check("wr_queue_drained", exp_wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
